completion_cdb_arbiter: RTL

//  Multi-channel completion stage. Gathers results from NUM_CH execution/memory pipes, buffers each
//  in a per-channel FIFO, picks one per cycle by round-robin, and broadcasts it on the common data bus.

---
 rtl/completion_cdb_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/completion_cdb_arbiter.sv
// completion_cdb_arbiter: per-channel result FIFOs, round-robin pick, registered CDB/ROB broadcast
module completion_cdb_arbiter #(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 64,
  parameter int FLAG_W     = 4,
  parameter int ROB_SIZE   = 32,
  parameter int TAG_W      = $clog2(ROB_SIZE + 1),
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          flush_i,
  input  logic [NUM_CH-1:0]             ch_valid_i,
  output logic [NUM_CH-1:0]             ch_ready_o,
  input  logic [NUM_CH*TAG_W-1:0]       ch_tag_i,
  input  logic [NUM_CH*DATA_W-1:0]      ch_data_i,
  input  logic [NUM_CH*FLAG_W-1:0]      ch_flags_i,
  input  logic [NUM_CH-1:0]             ch_save_cond_i,
  output logic                          cdb_valid_o,
  output logic [TAG_W-1:0]              cdb_tag_o,
  output logic [DATA_W:0]               cdb_val_o,
  output logic                          rob_wr_en_o,
  output logic [TAG_W-1:0]              rob_wr_addr_o,
  output logic [DATA_W+FLAG_W+1:0]      rob_wr_data_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int EW = 1 + FLAG_W + TAG_W + DATA_W;
  logic [EW-1:0] mem [NUM_CH][FIFO_DEPTH];
  logic [PW-1:0] head [NUM_CH];
  logic [PW-1:0] tail [NUM_CH];
  logic [CW-1:0] count [NUM_CH];
  logic [NUM_CH-1:0] push, pop, req;
  logic [SW-1:0] rr_ptr, grant;
  logic [SW:0] idx;
  logic granted;
  logic [EW-1:0] head_ent;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign req[c]        = count[c] != '0;
    assign ch_ready_o[c] = count[c] != CW'(FIFO_DEPTH);
    assign push[c]       = ch_valid_i[c] && ch_ready_o[c] && !flush_i && ch_tag_i[c*TAG_W +: TAG_W] != '0;
    assign pop[c]        = granted && grant == SW'(c);
  end
  always_comb begin
    grant = rr_ptr;
    granted = 1'b0;
    idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = {1'b0, rr_ptr} + (SW+1)'(i);
      idx = idx >= (SW+1)'(NUM_CH) ? idx - (SW+1)'(NUM_CH) : idx;
      if (!granted && req[idx[SW-1:0]]) begin
        grant = idx[SW-1:0];
        granted = 1'b1;
      end
    end
  end
  assign head_ent = mem[grant][head[grant]];
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        head[c] <= '0;
        tail[c] <= '0;
        count[c] <= '0;
      end
    end else if (flush_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        head[c] <= '0;
        tail[c] <= '0;
        count[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (push[c]) tail[c] <= tail[c] + 1'b1;
        if (pop[c]) head[c] <= head[c] + 1'b1;
        count[c] <= count[c] + CW'(push[c]) - CW'(pop[c]);
      end
    end
  end
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NUM_CH; c++)
      if (push[c])
        mem[c][tail[c]] <= {ch_save_cond_i[c], ch_flags_i[c*FLAG_W +: FLAG_W],
                            ch_tag_i[c*TAG_W +: TAG_W], ch_data_i[c*DATA_W +: DATA_W]};
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_ptr <= '0;
      cdb_valid_o <= 1'b0;
      cdb_tag_o <= '0;
      cdb_val_o <= '0;
      rob_wr_en_o <= 1'b0;
      rob_wr_addr_o <= '0;
      rob_wr_data_o <= '0;
    end else if (flush_i) begin
      rr_ptr <= '0;
      cdb_valid_o <= 1'b0;
      rob_wr_en_o <= 1'b0;
    end else begin
      cdb_valid_o <= granted;
      rob_wr_en_o <= granted;
      if (granted) begin
        rr_ptr <= grant == SW'(NUM_CH - 1) ? '0 : grant + 1'b1;
        cdb_tag_o <= head_ent[DATA_W +: TAG_W];
        rob_wr_addr_o <= head_ent[DATA_W +: TAG_W];
        cdb_val_o <= {1'b1, head_ent[DATA_W-1:0]};
        rob_wr_data_o <= {head_ent[EW-1], head_ent[DATA_W+TAG_W +: FLAG_W], 1'b1, head_ent[DATA_W-1:0]};
      end
    end
  end
endmodule
